custom_function_bank: RTL and testbench
=======================================

# custom_function_bank

Runtime-programmable bank of bit-sliced LUT functions for the processor's custom-function unit. It holds `NUM_FUNCS` functions. Each function applies an independent `ARITY`-input truth table per bit lane across `DATA_WIDTH`-bit operands. Tables are loaded through a valid/ready configuration stream into a shadow buffer and committed atomically, so evaluation traffic never sees a half-written function. Evaluation is a fixed 2-cycle pipeline with no backpressure.

## Interface
- `DATA_WIDTH`, 16: operand/result width, one LUT per bit lane.
- `ARITY`, 4: inputs per LUT. `TABLE_BITS = 2**ARITY`.
- `NUM_FUNCS`, 32: function slots. `FUNC_W = $clog2(NUM_FUNCS)`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  evaluation request.
- `in_func`  in  FUNC_W  function slot to evaluate.
- `in_data`  in  ARITY*DATA_WIDTH  operands. Operand k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid`  out  1  result valid.
- `out_data`  out  DATA_WIDTH  result.
- `cfg_valid`  in  1  configuration word offered.
- `cfg_ready`  out  1  configuration word accepted when `cfg_valid & cfg_ready`.
- `cfg_func`  in  FUNC_W  target slot. Sampled only on the first word of a load.
- `cfg_data`  in  TABLE_BITS  truth table for the current lane.
- `cfg_done`  out  1  one-cycle pulse after a commit.

## Operation
- Lane function: `out_data[i] = table[f][i][idx]`. `idx` concatenates bit i of operand 0 (MSB) down to operand ARITY-1 (LSB). For ARITY=4: `{x,y,u,v}`, x = operand 0.
- Reset value of every active-table entry: `TABLE_BITS'(1) << (TABLE_BITS-1)`, so every slot computes AND of all inputs. The shadow buffer resets to 0.
- Configuration FSM, states IDLE, LOAD, COMMIT:
  - IDLE: `cfg_ready=1`. On handshake, latch `cfg_func`, write shadow lane 0, set `lane_cnt=1`, go to LOAD. If `DATA_WIDTH==1`, go directly to COMMIT.
  - LOAD: `cfg_ready=1`. Each handshake writes shadow lane `lane_cnt` and increments it. The handshake writing lane `DATA_WIDTH-1` goes to COMMIT. `cfg_func` is ignored in LOAD.
  - COMMIT: `cfg_ready=0` for exactly one cycle. Copy the whole shadow into the active table of the latched slot at the clock edge ending COMMIT, then return to IDLE. `cfg_done` is registered high in the cycle after COMMIT.
- Lanes always load in ascending order (lane 0 first). No abort; a partial load stays in LOAD indefinitely.
- Evaluation runs concurrently with configuration and is never stalled.

## Timing
- Stage 1 registers `in_valid`, `in_func`, `in_data`. Stage 2 reads the active table and registers `out_data`/`out_valid`.
- Latency is exactly 2 cycles. A request at edge N produces its result at edge N+2. Throughput is 1 per cycle.
- Commit vs. eval: a stage-2 read in the COMMIT cycle sees the old table. Any read in a later cycle sees the new table. There is no forwarding.
- `out_data` holds its last value when `out_valid=0`. It is not cleared.
- Reset values: `out_valid=0`, `out_data=0`, `cfg_done=0`, `cfg_ready=0` while `reset_n=0` and `1` after release (FSM in IDLE), `lane_cnt=0`.
- Reset asserted mid-load or mid-eval: the FSM goes to IDLE, the partial shadow is discarded, all active tables return to their reset value, and the pipeline is flushed (`out_valid=0`). No outputs glitch after deassertion.
- `lane_cnt` width is `$clog2(DATA_WIDTH)` (min 1). It has no wrap-around, because COMMIT follows the final lane.

## Structure
- Package `custom_function_pkg` holds: `cfg_state_e` {IDLE, LOAD, COMMIT}, `TABLE_BITS` and `FUNC_W` derivation functions, and the reset table constant.
- Sub-module `custom_function_loader`: the config FSM, `lane_cnt`, the shadow buffer, and the commit strobe/slot outputs.
- Top level: the active table array as flops, the per-lane index mux, and the 2-stage evaluation pipeline.

## Test plan
- Post-reset default: `in_func=5`, operands 0xFFFF,0xFFFF,0xFFFF,0x00FF -> after 2 cycles `out_data=0x00FF` (AND).
- Program XOR4 (table 0x6996 on all 16 lanes) into slot 3 -> `cfg_ready` low for 1 cycle, then `cfg_done` pulse. Evaluating operands 0x0001,0,0,0 on slot 3 -> `0x0001`.
- Per-lane distinct tables: lane i = `0xFFFF` for even i, `0x0000` for odd i. Any operands -> `0x5555`.
- Commit race: stream slot-3 evals every cycle across the COMMIT cycle. The read in COMMIT yields the old result; the next read yields the new one. `out_valid` never drops.
- `cfg_valid` gaps during LOAD (idle cycles between lanes) -> same committed table as a back-to-back load. `cfg_func` changed mid-load is ignored.
- Assert `reset_n=0` after 7 of 16 lanes of a load -> slot is unchanged (AND), FSM in IDLE, `out_valid=0`. A fresh full load afterwards succeeds.

Source files
------------

// File: rtl/custom_function_pkg.sv
`default_nettype none
// ============================================================================
// custom_function_pkg : shared types and derivations for the LUT function bank
// Rev 1.0 - initial release
// ============================================================================
package custom_function_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_LOAD   = 2'd1,
        CFG_COMMIT = 2'd2
    } cfg_state_e;

    localparam int MAX_TABLE_BITS = 256;

    function automatic int calc_table_bits(input int arity);
        return 1 << arity;
    endfunction

    function automatic int calc_func_w(input int num_funcs);
        return (num_funcs > 1) ? $clog2(num_funcs) : 1;
    endfunction

    function automatic int calc_lane_w(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

    // Only the top entry is set, so every input combination but all-ones yields 0 (AND).
    function automatic logic [MAX_TABLE_BITS-1:0] reset_table(input int table_bits);
        return {{(MAX_TABLE_BITS-1){1'b0}}, 1'b1} << (table_bits - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/custom_function_loader.sv
`default_nettype none
// ============================================================================
// custom_function_loader : config stream FSM, lane counter and shadow buffer
// Rev 1.0 - initial release
// ============================================================================
module custom_function_loader
    import custom_function_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TABLE_BITS = 16,
    parameter int FUNC_W     = 5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_valid,
    input  logic [FUNC_W-1:0]                      cfg_func,
    input  logic [TABLE_BITS-1:0]                  cfg_data,
    output logic                                   cfg_ready,
    output logic                                   cfg_done,
    output logic                                   commit_en,
    output logic [FUNC_W-1:0]                      commit_func,
    output logic [DATA_WIDTH-1:0][TABLE_BITS-1:0]  shadow
);

    localparam int                LANE_W    = calc_lane_w(DATA_WIDTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATA_WIDTH - 1);

    cfg_state_e                            state_q, state_d;
    logic [LANE_W-1:0]                     lane_cnt_q, lane_cnt_d;
    logic [FUNC_W-1:0]                     func_q, func_d;
    logic [DATA_WIDTH-1:0][TABLE_BITS-1:0] shadow_q, shadow_d;
    logic                                  done_q, done_d;
    logic                                  hs;

    assign hs = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CFG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_IDLE:   if (hs) state_d = (DATA_WIDTH == 1) ? CFG_COMMIT : CFG_LOAD;
            CFG_LOAD:   if (hs && (lane_cnt_q == LAST_LANE)) state_d = CFG_COMMIT;
            CFG_COMMIT: state_d = CFG_IDLE;
            default:    state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = rst_n && (state_q != CFG_COMMIT);
        commit_en = (state_q == CFG_COMMIT);
    end

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        func_d     = func_q;
        shadow_d   = shadow_q;
        done_d     = (state_q == CFG_COMMIT);
        case (state_q)
            CFG_IDLE: begin
                if (hs) begin
                    func_d      = cfg_func;
                    shadow_d[0] = cfg_data;
                    lane_cnt_d  = LANE_W'(1);
                end
            end
            CFG_LOAD: begin
                if (hs) begin
                    shadow_d[lane_cnt_q] = cfg_data;
                    lane_cnt_d = (lane_cnt_q == LAST_LANE) ? '0 : lane_cnt_q + 1'b1;
                end
            end
            default: begin
                lane_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_q <= '0;
            func_q     <= '0;
            shadow_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            func_q     <= func_d;
            shadow_q   <= shadow_d;
            done_q     <= done_d;
        end
    end

    assign cfg_done    = done_q;
    assign commit_func = func_q;
    assign shadow      = shadow_q;

endmodule
`default_nettype wire

// File: rtl/custom_function_bank.sv
`default_nettype none
// ============================================================================
// custom_function_bank : runtime-programmable bit-sliced LUT bank, 2-cycle eval
// Rev 1.0 - initial release
// ============================================================================
module custom_function_bank
    import custom_function_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int ARITY      = 4,
    parameter  int NUM_FUNCS  = 32,
    localparam int TABLE_BITS = calc_table_bits(ARITY),
    localparam int FUNC_W     = calc_func_w(NUM_FUNCS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [FUNC_W-1:0]           in_func,
    input  logic [ARITY*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [FUNC_W-1:0]           cfg_func,
    input  logic [TABLE_BITS-1:0]       cfg_data,
    output logic                        cfg_done
);

    localparam logic [MAX_TABLE_BITS-1:0] RESET_FULL  = reset_table(TABLE_BITS);
    localparam logic [TABLE_BITS-1:0]     RESET_TABLE = RESET_FULL[TABLE_BITS-1:0];

    logic                                  commit_en;
    logic [FUNC_W-1:0]                     commit_func;
    logic [DATA_WIDTH-1:0][TABLE_BITS-1:0] shadow;

    custom_function_loader #(
        .DATA_WIDTH (DATA_WIDTH),
        .TABLE_BITS (TABLE_BITS),
        .FUNC_W     (FUNC_W)
    ) u_loader (
        .clk         (clock),
        .rst_n       (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_func    (cfg_func),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .cfg_done    (cfg_done),
        .commit_en   (commit_en),
        .commit_func (commit_func),
        .shadow      (shadow)
    );

    logic [DATA_WIDTH-1:0][TABLE_BITS-1:0] table_q [NUM_FUNCS];
    logic [DATA_WIDTH-1:0][TABLE_BITS-1:0] table_d [NUM_FUNCS];

    // The whole slot is replaced in one edge, so stage 2 never sees a mix of old and new lanes.
    always_comb begin
        table_d = table_q;
        if (commit_en) table_d[commit_func] = shadow;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int f = 0; f < NUM_FUNCS; f++) begin
                table_q[f] <= {DATA_WIDTH{RESET_TABLE}};
            end
        end else begin
            table_q <= table_d;
        end
    end

    logic                        s1_valid_q, s1_valid_d;
    logic [FUNC_W-1:0]           s1_func_q, s1_func_d;
    logic [ARITY*DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                        out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0]       lane_result;

    // Operand 0 supplies the index MSB, operand ARITY-1 the LSB.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
        logic [ARITY-1:0] idx;
        always_comb begin
            idx = '0;
            for (int k = 0; k < ARITY; k++) begin
                idx[ARITY-1-k] = s1_data_q[k*DATA_WIDTH + i];
            end
        end
        assign lane_result[i] = table_q[s1_func_q][i][idx];
    end

    always_comb begin
        s1_valid_d  = in_valid;
        s1_func_d   = in_func;
        s1_data_d   = in_data;
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? lane_result : out_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_func_q   <= '0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_func_q   <= s1_func_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_custom_function_bank.sv
`default_nettype none
// ============================================================================
// tb_custom_function_bank : directed + randomized check against a table model
// Rev 1.0 - initial release
// ============================================================================
module tb_custom_function_bank;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid;
    logic [4:0]  in_func;
    logic [63:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_func;
    logic [15:0] cfg_data;
    logic        cfg_done;

    int n_checks = 0;
    int n_errors = 0;

    custom_function_bank dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_func   (in_func),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_func  (cfg_func),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done)
    );

    always #5 clock = ~clock;

    // Reference model: truth tables per slot/lane, a two-deep request pipe, lane-count loader.
    logic [15:0] m_tab [32][16];
    logic [15:0] m_shadow [16];
    logic        m_s1_v, m_out_v, m_done, m_pend;
    logic [4:0]  m_s1_f, m_slot;
    logic [63:0] m_s1_d;
    logic [15:0] m_out_d;
    int          m_cnt;

    function automatic logic [15:0] ref_eval(input logic [4:0] f, input logic [63:0] ops);
        logic [15:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            idx = 0;
            for (int k = 0; k < 4; k++) idx = idx * 2 + int'(ops[k*16 + i]);
            r[i] = m_tab[f][i][idx];
        end
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int f = 0; f < 32; f++)
                for (int l = 0; l < 16; l++) m_tab[f][l] <= 16'h8000;
            m_s1_v  <= 1'b0;
            m_s1_f  <= '0;
            m_s1_d  <= '0;
            m_out_v <= 1'b0;
            m_out_d <= '0;
            m_done  <= 1'b0;
            m_pend  <= 1'b0;
            m_cnt   <= 0;
            m_slot  <= '0;
        end else begin
            m_out_v <= m_s1_v;
            if (m_s1_v) m_out_d <= ref_eval(m_s1_f, m_s1_d);
            m_s1_v <= in_valid;
            m_s1_f <= in_func;
            m_s1_d <= in_data;
            m_done <= m_pend;
            if (m_pend) begin
                for (int l = 0; l < 16; l++) m_tab[m_slot][l] <= m_shadow[l];
                m_pend <= 1'b0;
            end else if (cfg_valid) begin
                if (m_cnt == 0) m_slot <= cfg_func;
                m_shadow[m_cnt] <= cfg_data;
                if (m_cnt == 15) begin
                    m_cnt  <= 0;
                    m_pend <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        check("cfg_ready", 16'(cfg_ready), 16'(reset_n && !m_pend));
        check("cfg_done", 16'(cfg_done), 16'(m_done));
        check("out_valid", 16'(out_valid), 16'(m_out_v));
        check("out_data", out_data, m_out_d);
    endtask

    task automatic drive_rand_eval();
        in_valid = 1'($urandom);
        in_func  = 5'($urandom);
        in_data  = {$urandom, $urandom};
    endtask

    task automatic cfg_load(input logic [4:0] slot, input logic [15:0] tabs [16],
                            input bit gaps, input bit rnd_eval);
        int lane;
        lane = 0;
        while (lane < 16) begin
            if (rnd_eval) drive_rand_eval();
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                cfg_valid = 1'b0;
                cfg_func  = 5'($urandom);
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = tabs[lane];
                cfg_func  = (lane == 0) ? slot : 5'($urandom);
                lane++;
            end
            cycle();
        end
        cfg_valid = 1'b0;
        if (rnd_eval) drive_rand_eval();
        check("commit_ready_low", 16'(cfg_ready), 16'h0000);
        cycle();
        check("done_pulse", 16'(cfg_done), 16'h0001);
        check("ready_after_commit", 16'(cfg_ready), 16'h0001);
    endtask

    task automatic eval_once(input logic [4:0] f, input logic [63:0] ops);
        in_valid = 1'b1;
        in_func  = f;
        in_data  = ops;
        cycle();
        in_valid = 1'b0;
        cycle();
    endtask

    logic [15:0] tabs [16];
    logic [15:0] o0, o1, o2, o3;

    initial begin
        in_valid  = 1'b0;
        in_func   = '0;
        in_data   = '0;
        cfg_valid = 1'b0;
        cfg_func  = '0;
        cfg_data  = '0;

        repeat (3) cycle();
        check("reset_cfg_ready", 16'(cfg_ready), 16'h0000);
        check("reset_out_valid", 16'(out_valid), 16'h0000);
        check("reset_out_data", out_data, 16'h0000);
        check("reset_cfg_done", 16'(cfg_done), 16'h0000);
        reset_n = 1'b1;
        cycle();
        check("idle_ready", 16'(cfg_ready), 16'h0001);

        // Default AND on slot 5.
        eval_once(5'd5, {16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        check("default_and", out_data, 16'h00FF);
        check("default_and_valid", 16'(out_valid), 16'h0001);
        cycle();
        check("hold_data", out_data, 16'h00FF);
        check("hold_valid_low", 16'(out_valid), 16'h0000);

        // XOR4 on slot 3.
        for (int i = 0; i < 16; i++) tabs[i] = 16'h6996;
        cfg_load(5'd3, tabs, 1'b0, 1'b1);
        in_valid = 1'b0;
        cycle();
        check("done_one_cycle", 16'(cfg_done), 16'h0000);
        eval_once(5'd3, {48'h0, 16'h0001});
        check("xor4_basic", out_data, 16'h0001);
        for (int n = 0; n < 6; n++) begin
            o0 = 16'($urandom); o1 = 16'($urandom); o2 = 16'($urandom); o3 = 16'($urandom);
            eval_once(5'd3, {o3, o2, o1, o0});
            check("xor4_rand", out_data, o0 ^ o1 ^ o2 ^ o3);
        end

        // Alternating per-lane tables, loaded with gaps and a wandering cfg_func.
        for (int i = 0; i < 16; i++) tabs[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
        cfg_load(5'd7, tabs, 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            eval_once(5'd7, {$urandom, $urandom});
            check("per_lane", out_data, 16'h5555);
        end

        // Commit race: slot 3 streamed every cycle while it is replaced by all-zero tables.
        for (int i = 0; i < 16; i++) tabs[i] = 16'h0000;
        in_valid = 1'b1;
        in_func  = 5'd3;
        in_data  = {48'h0, 16'h0001};
        cfg_load(5'd3, tabs, 1'b0, 1'b0);
        check("race_old_table", out_data, 16'h0001);
        check("race_valid_old", 16'(out_valid), 16'h0001);
        cycle();
        check("race_new_table", out_data, 16'h0000);
        check("race_valid_new", 16'(out_valid), 16'h0001);
        in_valid = 1'b0;

        // Random loads into random slots with random concurrent traffic.
        repeat (3) begin
            for (int i = 0; i < 16; i++) tabs[i] = 16'($urandom);
            cfg_load(5'($urandom_range(10, 31)), tabs, 1'($urandom), 1'b1);
            repeat (12) begin
                drive_rand_eval();
                cycle();
            end
        end

        // Reset in the middle of a load.
        for (int l = 0; l < 7; l++) begin
            cfg_valid = 1'b1;
            cfg_func  = 5'd9;
            cfg_data  = 16'h6996;
            drive_rand_eval();
            in_valid = 1'b1;
            cycle();
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("midreset_out_valid", 16'(out_valid), 16'h0000);
        check("midreset_ready", 16'(cfg_ready), 16'h0000);
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        check("post_reset_ready", 16'(cfg_ready), 16'h0001);
        eval_once(5'd9, {16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        check("slot9_still_and", out_data, 16'h00FF);
        eval_once(5'd3, {16'h0F0F, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        check("slot3_back_to_and", out_data, 16'h0F0F);
        for (int i = 0; i < 16; i++) tabs[i] = 16'h6996;
        cfg_load(5'd9, tabs, 1'b0, 1'b1);
        eval_once(5'd9, {48'h0, 16'h0001});
        check("fresh_load_xor", out_data, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
